// File: rtl/at_vec_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// at_vec_driver
//
// Purpose:
//   Self-test stimulus driver for a 128-bit popcount unit. On request it issues
//   num_vec structured vectors (a run of t low ones, rotated left by r). It also
//   records each expected popcount t in a 4-entry FIFO. Results returned by the
//   unit are checked against that FIFO. When the run ends, the driver reports a
//   pass/fail verdict, an error count and a drain-timeout flag.
//
// Configuration:
//   AT_DRV_LFSR_EN  When defined, the rotation r comes from a 32-bit Fibonacci
//                   LFSR (taps 32,22,2,1). The LFSR is seeded from `seed` when
//                   start is accepted; a zero seed is replaced by 32'h1.
//                   When undefined (the default), r = vector index [6:0] and
//                   `seed` is ignored.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    run request, honoured only in IDLE
//   num_vec    in   8    vectors in the run, captured with start
//   seed       in   32   LFSR seed, captured with start
//   in_valid   out  1    vector strobe to the popcount unit
//   A          out  128  vector to the popcount unit (zero when idle)
//   out_valid  in   1    result strobe from the popcount unit
//   out_data   in   8    popcount result
//   busy       out  1    high in SEND and DRAIN
//   done       out  1    one-cycle pulse at end of run
//   pass       out  1    verdict; valid with done, held until next start
//   err_cnt    out  8    mismatches + unexpected results, saturating
//   timeout    out  1    drain stalled for 16 cycles
// -----------------------------------------------------------------------------
module at_vec_driver (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   num_vec,
    input  logic [31:0]  seed,
    output logic         in_valid,
    output logic [127:0] A,
    input  logic         out_valid,
    input  logic [7:0]   out_data,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_cnt,
    output logic         timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] FIFO_DEPTH   = 3'd4;
    localparam logic [3:0] IDLE_LIMIT   = 4'd15;  // 16th silent DRAIN cycle

    state_t       r_state;
    state_t       w_state_next;

    logic [7:0]   r_num_vec;
    logic [7:0]   r_idx;        // vectors issued so far (= index of next vector)
    logic [7:0]   r_rcv;        // results matched against the FIFO
    logic [3:0]   r_idle;       // consecutive DRAIN cycles without out_valid
    logic [7:0]   r_err;
    logic         r_timeout;
    logic         r_pass;

    // Expected-result FIFO
    logic [7:0]   r_fifo_mem [4];
    logic [1:0]   r_wr_ptr;
    logic [1:0]   r_rd_ptr;
    logic [2:0]   r_fifo_cnt;

    logic         w_start_acc;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_issue;
    logic         w_counting;
    logic         w_pop;
    logic         w_unexp;
    logic         w_mismatch;
    logic         w_err_inc;
    logic         w_last_issue;
    logic         w_rcv_done;
    logic         w_drain_to;
    logic         w_verdict;

    logic [7:0]   w_t;
    logic [6:0]   w_rot;
    logic [7:0]   w_rot_comp;
    logic [127:0] w_mask;
    logic [127:0] w_rotated;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_fifo_full  = (r_fifo_cnt == FIFO_DEPTH);
    assign w_fifo_empty = (r_fifo_cnt == 3'd0);

    // A vector goes out every SEND cycle unless there is nowhere to record
    // its expected result.
    assign w_issue      = (r_state == S_SEND) && !w_fifo_full;
    assign w_last_issue = w_issue && (r_idx == (r_num_vec - 8'd1));

    // Results are only interpreted while a run is in flight.
    assign w_counting   = (r_state == S_SEND) || (r_state == S_DRAIN);
    assign w_pop        = out_valid && w_counting && !w_fifo_empty;
    assign w_unexp      = out_valid && w_counting && w_fifo_empty;
    assign w_mismatch   = w_pop && (r_fifo_mem[r_rd_ptr] != out_data);
    assign w_err_inc    = w_mismatch || w_unexp;

    assign w_rcv_done   = (r_rcv == r_num_vec);
    // Completion wins over timeout if both would fire in the same cycle.
    assign w_drain_to   = (r_state == S_DRAIN) && !w_rcv_done && !out_valid &&
                          (r_idle == IDLE_LIMIT);

    assign w_verdict    = (r_err == 8'd0) && !r_timeout;

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_vec == 8'd0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_rcv_done || w_drain_to) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Vector generation
    // -------------------------------------------------------------------------
    // Indices 0..128 give t = 0..128; indices 129..254 wrap to t = 0..125.
    assign w_t = (r_idx <= 8'd128) ? r_idx : (r_idx - 8'd129);

    // Thermometer mask with the low t bits set; t = 128 lights every bit.
    generate
        for (genvar gi = 0; gi < 128; gi++) begin : g_mask
            localparam logic [7:0] BIT_IDX = 8'(gi);
            assign w_mask[gi] = (BIT_IDX < w_t);
        end
    endgenerate

`ifdef AT_DRV_LFSR_EN
    logic [31:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 32'h1;
        end else if (w_start_acc) begin
            // An all-zero LFSR would lock up.
            r_lfsr <= (seed == 32'd0) ? 32'h1 : seed;
        end else if (w_issue) begin
            r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
        end
    end

    assign w_rot = r_lfsr[6:0];
`else
    logic w_unused_seed;
    assign w_unused_seed = ^seed;
    assign w_rot = r_idx[6:0];
`endif

    // Rotate-left by w_rot. For w_rot == 0 the right shift is by the full
    // width and contributes nothing, which is the desired result.
    assign w_rot_comp = 8'd128 - {1'b0, w_rot};
    assign w_rotated  = (w_mask << w_rot) | (w_mask >> w_rot_comp);

    assign in_valid = w_issue;
    assign A        = w_issue ? w_rotated : 128'd0;

    // -------------------------------------------------------------------------
    // Expected FIFO
    // -------------------------------------------------------------------------
    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fifo_mem[r_wr_ptr] <= w_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_fifo_cnt <= 3'd0;
        end else if (w_start_acc) begin
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_fifo_cnt <= 3'd0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({w_issue, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Run counters, error accounting and verdict
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vec <= 8'd0;
            r_idx     <= 8'd0;
            r_rcv     <= 8'd0;
            r_idle    <= 4'd0;
            r_err     <= 8'd0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
        end else if (w_start_acc) begin
            r_num_vec <= num_vec;
            r_idx     <= 8'd0;
            r_rcv     <= 8'd0;
            r_idle    <= 4'd0;
            r_err     <= 8'd0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_idx <= r_idx + 8'd1;
            end
            if (w_pop) begin
                r_rcv <= r_rcv + 8'd1;
            end
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
            // Silence counter only runs in DRAIN and restarts on any result.
            if ((r_state == S_DRAIN) && !out_valid) begin
                r_idle <= r_idle + 4'd1;
            end else begin
                r_idle <= 4'd0;
            end
            if (w_drain_to) begin
                r_timeout <= 1'b1;
            end
            // Latch the verdict so it stays visible after the done pulse.
            if (r_state == S_DONE) begin
                r_pass <= w_verdict;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign busy    = (r_state == S_SEND) || (r_state == S_DRAIN);
    assign done    = (r_state == S_DONE);
    // During the done pulse the verdict is shown live; afterwards it is held.
    assign pass    = (r_state == S_DONE) ? w_verdict : r_pass;
    assign err_cnt = r_err;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_at_vec_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_at_vec_driver
//
// Table of runs applied in a loop. Each run's expected vectors are queued when
// start is driven and popped as the DUT raises in_valid. A behavioural popcount
// unit (1-cycle latency) answers each vector; per-run modes corrupt, suppress
// or inject results. Hand-written sequences cover reset state and async reset
// mid-run.
// -----------------------------------------------------------------------------
module tb_at_vec_driver;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   num_vec = 8'd0;
    logic [31:0]  seed = 32'd0;
    logic         in_valid;
    logic [127:0] A;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_cnt;
    logic         timeout;

    at_vec_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_vec   (num_vec),
        .seed      (seed),
        .in_valid  (in_valid),
        .A         (A),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- popcount unit model ----------------
    // mode: 0 ideal, 1 out_data forced FF, 2 out_valid suppressed,
    //       3 one injected out_valid in first SEND cycle,
    //       4 out_valid held high and out_data forced FF
    int          mode = 0;
    logic        inj = 1'b0;
    logic        mdl_valid = 1'b0;
    logic [7:0]  mdl_data = 8'd0;

    always @(posedge clk) begin
        mdl_valid <= in_valid;
        mdl_data  <= 8'($countones(A));
    end

    assign out_valid = inj | (mdl_valid & (mode != 2));
    assign out_data  = ((mode == 1) || (mode == 4)) ? 8'hFF : mdl_data;

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %032h, expected %032h", nm, got, want);
        end
    endtask

    function automatic logic [127:0] exp_vec(input int i, input int r);
        int t;
        logic [127:0] m;
        logic [127:0] a;
        t = (i <= 128) ? i : i - 129;
        m = '0;
        a = '0;
        for (int b = 0; b < 128; b++) m[b] = (b < t);
        for (int b = 0; b < 128; b++) a[(b + r) % 128] = m[b];
        return a;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int           iv_count = 0;
    int           last_iv_cyc = 0;

    task automatic push_expected(input int n, input logic [31:0] sd);
        int r;
`ifdef AT_DRV_LFSR_EN
        logic [31:0] l;
        l = (sd == 32'd0) ? 32'h1 : sd;
`else
        logic [31:0] unused_sd;
        unused_sd = sd;
`endif
        for (int i = 0; i < n; i++) begin
`ifdef AT_DRV_LFSR_EN
            r = int'(l[6:0]);
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
`else
            r = i % 128;
`endif
            exp_q.push_back(exp_vec(i, r));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid) begin
            iv_count++;
            last_iv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_vector: got in_valid with A=%032h, expected none", A);
            end else begin
                chk_vec("vector_A", A, exp_q.pop_front());
            end
        end
    end

    // ---------------- run table ----------------
    typedef struct {
        int          n;
        logic [31:0] sd;
        int          md;
        int          restart;
        int          exp_err;
        int          exp_pass;
        int          exp_to;
        int          lat_max;    // start->done cycles bound, -1 unused
        int          drain_max;  // DRAIN cycles bound, -1 unused
        int          drain_eq;   // exact DRAIN cycles, -1 unused
    } case_t;

    case_t tbl[9];

    task automatic run_case(input int idx, input case_t v);
        int s;
        int got;
        int done_cyc;
        got = 0;
        done_cyc = 0;
        @(negedge clk);
        exp_q.delete();
        iv_count = 0;
        push_expected(v.n, v.sd);
        mode = v.md;
        if (v.md == 4) inj = 1'b1;
        start = 1'b1;
        num_vec = 8'(v.n);
        seed = v.sd;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (v.md == 3) inj = 1'b1;
        for (int k = 0; k < 700; k++) begin
            if (done) begin
                got = 1;
                done_cyc = cyc;
                break;
            end
            if (k == 1 && v.md == 3) inj = 1'b0;
            if (k == 1 && v.restart != 0) begin
                start = 1'b1;
                num_vec = 8'd1;
            end
            if (k == 2 && v.restart != 0) start = 1'b0;
            @(negedge clk);
        end
        chk("done_seen", got, 1);
        if (got == 1) begin
            chk("pass", int'(pass), v.exp_pass);
            chk("err_cnt", int'(err_cnt), v.exp_err);
            chk("timeout", int'(timeout), v.exp_to);
            chk("vectors_issued", iv_count, v.n);
            chk("vectors_pending", exp_q.size(), 0);
            if (v.lat_max >= 0) chk("done_latency_ok", int'((done_cyc - s) <= v.lat_max), 1);
            if (v.drain_max >= 0) chk("drain_cycles_ok", int'((done_cyc - last_iv_cyc - 1) <= v.drain_max), 1);
            if (v.drain_eq >= 0) chk("drain_cycles", done_cyc - last_iv_cyc - 1, v.drain_eq);
            if (v.md == 2) chk("fifo_occupancy", int'(dut.r_fifo_cnt), v.n);
        end
        $display("[TB] case %0d n=%0d mode=%0d err_cnt=%0d pass=%0b timeout=%0b vectors=%0d",
                 idx, v.n, v.md, err_cnt, pass, timeout, iv_count);
        @(negedge clk);
        inj = 1'b0;
        mode = 0;
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        @(negedge clk);
        chk("pass_held", int'(pass), v.exp_pass);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int done_hits;
        tbl[0] = '{3,   32'h0,        0, 1, 0,   1, 0, -1,  5, -1};
        tbl[1] = '{130, 32'h0,        0, 0, 0,   1, 0, -1, -1, -1};
        tbl[2] = '{4,   32'h0,        1, 0, 4,   0, 0, -1, -1, -1};
        tbl[3] = '{2,   32'h0,        2, 0, 0,   0, 1, -1, -1, 16};
        tbl[4] = '{1,   32'h0,        3, 0, 1,   0, 0, -1, -1, -1};
        tbl[5] = '{0,   32'h0,        0, 0, 0,   1, 0,  2, -1, -1};
        tbl[6] = '{255, 32'hDEADBEEF, 0, 0, 0,   1, 0, -1, -1, -1};
        tbl[7] = '{255, 32'h0,        4, 0, 255, 0, 0, -1, -1, -1};
        tbl[8] = '{5,   32'h12345678, 0, 0, 0,   1, 0, -1, -1, -1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_valid", int'(in_valid), 0);
        chk_vec("rst_A", A, 128'd0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_case(i, tbl[i]);

        // Asynchronous reset in the middle of a long run with errors pending
        @(negedge clk);
        exp_q.delete();
        push_expected(200, 32'h0);
        mode = 1;
        start = 1'b1;
        num_vec = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_run_busy", int'(busy), 1);
        chk("mid_run_err_nonzero", int'(err_cnt != 8'd0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_valid", int'(in_valid), 0);
        chk_vec("arst_A", A, 128'd0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_pass", int'(pass), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        chk("arst_timeout", int'(timeout), 0);
        chk("arst_fifo_empty", int'(dut.r_fifo_cnt), 0);
        exp_q.delete();
        mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        done_hits = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        chk("no_done_after_reset", done_hits, 0);
        $display("[TB] case reset_mid_send n=200 done_pulses=%0d", done_hits);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500us");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/at_vec_driver.md
AT_VEC_DRIVER -- requirements
Module: at_vec_driver

Interface
REQ-001 SHALL have port clk  input  1  clock; rising-edge active.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-004 SHALL have port num_vec  input  8  number of vectors in the run; sampled with start.
REQ-005 SHALL have port seed  input  32  LFSR seed; sampled with start.
REQ-006 SHALL have port in_valid  output  1  vector-valid strobe to the popcount unit.
REQ-007 SHALL have port A  output  128  vector to the popcount unit.
REQ-008 SHALL have port out_valid  input  1  result-valid strobe from the popcount unit.
REQ-009 SHALL have port out_data  input  8  popcount result from the popcount unit.
REQ-010 SHALL have port busy  output  1  high in SEND and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a run ends.
REQ-012 SHALL have port pass  output  1  run verdict; held from done until the next accepted start.
REQ-013 SHALL have port err_cnt  output  8  mismatch/unexpected-result count; saturates at 255.
REQ-014 SHALL have port timeout  output  1  drain timeout flag.

Function
REQ-015 SHALL implement states IDLE, SEND, DRAIN, DONE.
  - IDLE->SEND on start with num_vec>0.
  - IDLE->DONE on start with num_vec==0.
  - SEND->DRAIN after the num_vec-th vector is issued.
  - DRAIN->DONE when received count == num_vec, or on timeout.
  - DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL assert in_valid in SEND for one vector per cycle, starting the cycle after start is accepted, unless the expected FIFO is full.
REQ-018 SHALL, for vector index i (0..num_vec-1), set t = i when i<=128, else t = i-129, and drive A = rotate-left(low t bits set, r).
REQ-019 SHALL, for t=0, drive A all zeros; for t=128, drive A all ones.
REQ-020 SHALL push t (8 bits) into a 4-entry expected FIFO in the same cycle in_valid is high.
REQ-021 SHALL drive in_valid=0 and A=0 whenever no vector is issued.
REQ-022 SHALL, on out_valid with the FIFO non-empty, pop the FIFO, compare with out_data, and increment err_cnt on mismatch.
REQ-023 SHALL, on out_valid with the FIFO empty, increment err_cnt (unexpected result) and not change the received count.
REQ-024 SHALL handle push and pop in the same cycle with no change in occupancy.
REQ-025 SHALL count out_valid only in SEND/DRAIN; out_valid in IDLE/DONE is ignored.
REQ-026 SHALL, in DRAIN, set timeout=1 and go to DONE after 16 consecutive cycles without out_valid.
REQ-027 SHALL pulse done=1 in DONE with pass = (err_cnt==0 && timeout==0).
REQ-028 SHALL clear err_cnt, timeout, pass and the FIFO when start is accepted.

Reset
REQ-029 SHALL on rst_n low immediately set state=IDLE, in_valid=0, A=0, busy=0, done=0, pass=0, err_cnt=0, timeout=0, FIFO empty, all counters 0, LFSR=32'h1.
REQ-030 SHALL abort any run on reset mid-operation with no done pulse.

Configuration
REQ-031 SHALL, with AT_DRV_LFSR_EN defined:
  - load a 32-bit Fibonacci LFSR (taps 32,22,2,1) from seed at start, using 32'h1 when seed==0;
  - advance the LFSR once per issued vector;
  - use r = LFSR[6:0].
REQ-032 SHALL, without AT_DRV_LFSR_EN, use r = i[6:0] and ignore seed.

Verification
REQ-033 SHALL verify: num_vec=3, ideal popcount unit with 1-cycle latency -> A = 0, 1<<r, 3<<r; out_data 0,1,2; done after 5 cycles in DRAIN at most; pass=1; err_cnt=0.
REQ-034 SHALL verify: num_vec=130, without the macro -> vector 128 is all ones with expected 128, vector 129 has t=0; pass=1.
REQ-035 SHALL verify: num_vec=4 with out_data forced to 8'hFF -> err_cnt=4, pass=0.
REQ-036 SHALL verify: num_vec=2 with out_valid never asserted -> FIFO holds 2 entries, timeout=1 16 cycles after DRAIN entry, done pulse, pass=0.
REQ-037 SHALL verify: num_vec=0 -> done pulse 2 cycles after start, pass=1, in_valid never high; an extra out_valid pulse in SEND with the FIFO empty -> err_cnt=1.
REQ-038 SHALL verify: rst_n low mid-SEND with num_vec=200 -> all outputs return to reset values asynchronously and no done pulse occurs.
